ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data block RAM (10-bit word address, 32-bit data).
- Port m0 is the CPU-side bus path from the MIO bus decoder; port m1 is a secondary master such as a debug loader or DMA engine.
- Serialises accesses, drives the RAM write-enable, address and data-in, and returns read data with a valid pulse.
- Clocked by the 100 MHz system clock, the same clock as the RAM.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in cycles from address presented to ram_dout valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on rising edge
- RSTN  in  1  synchronous active-low reset
- m0_req  in  1  m0 access request; held until m0_gnt
- m0_we  in  1  1 = write, 0 = read; valid with m0_req
- m0_addr  in  ADDR_W  m0 word address
- m0_wdata  in  DATA_W  m0 write data
- m0_gnt  out  1  one-cycle pulse: m0 request accepted
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  DATA_W  m0 read data; holds until the next m0 read returns
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (RSTN low at a rising clk edge):
  - FSM goes to IDLE; every output goes to 0.
  - rr_last = 1, so m0 wins the first contention.
  - Any in-flight access is dropped: no ram_we and no rvalid is issued for it after reset.
- FSM states:
  - IDLE: arbitrate among requests asserted this cycle.
    - No request: stay in IDLE.
    - Otherwise choose a winner and latch its we/addr/wdata and its index into internal registers.
    - Next state is ACCESS.
  - ACCESS (1 cycle):
    - gnt of the winner = 1.
    - ram_addr = latched address.
    - For a write: ram_we = 1 and ram_din = latched data; next state is IDLE.
    - For a read: ram_we = 0; next state is WAIT.
  - WAIT: count RD_LAT cycles, counting the ACCESS cycle as cycle 0.
    - On the cycle the count reaches RD_LAT, capture ram_dout into the winner's rdata register.
    - The winner's rvalid = 1 in the following cycle, in state DONE; then go to IDLE.
- ram_addr holds its last value outside ACCESS. ram_we is 1 only in the ACCESS cycle of a write.
- Latency, measured from the IDLE cycle in which req is sampled:
  - gnt at +1.
  - A write reaches the RAM at the end of +1.
  - rvalid at +RD_LAT+2.
  - Occupancy: write 2 cycles; read RD_LAT+3 cycles.
- Arbitration is round-robin:
  - Single requester wins.
  - Both requesting: the port that is not rr_last wins.
  - rr_last updates to the winner at the IDLE→ACCESS transition.
- Request rules:
  - Requests arriving while busy are not sampled until IDLE. The requester keeps req and its payload stable until gnt.
  - A req deasserted before being sampled is ignored, with no side effect.
  - Requester inputs are not re-read after latching: payload changes after the sampling cycle do not affect the access.
- Only one gnt and at most one rvalid are asserted in any cycle. gnt and rvalid never go to the non-winning port.
- Back-to-back: a port that keeps req high after gnt is granted again only if the other port is not requesting in the next IDLE cycle.
- A read and a write to the same address in consecutive accesses are strictly ordered by grant order.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority; m0 wins every contention and rr_last is unused. m1 can be starved while m0 holds req continuously.
- Undefined: round-robin as specified above.

Test Plan:
- RSTN=0 for 3 cycles with both req=1 → all outputs 0, busy=0, no ram_we. Release reset → m0 granted first.
- m0 write addr=0x005 data=0xDEADBEEF → m0_gnt at +1; ram_we=1 with ram_addr=0x005, ram_din=0xDEADBEEF in that same cycle; busy low again at +2.
- m1 read addr=0x005 after the previous write, RD_LAT=1 → m1_rvalid pulse at +3 with m1_rdata=0xDEADBEEF; m0_rvalid stays 0.
- Both req held high, four grants → grant order m0, m1, m0, m1. With ARB_FIXED_PRIO_EN defined → m0 ×4, m1 never.
- RSTN low during WAIT of an m0 read → no m0_rvalid; m0_rdata=0; FSM in IDLE next cycle.
- RD_LAT=3, m0 read addr=0x3FF (wrap boundary) preloaded with 0x12345678 → m0_rvalid at +5, data 0x12345678; m1 req raised mid-read is granted only after DONE.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data RAM.
// Define ARB_FIXED_PRIO_EN to make m0 win every contention instead of round-robin.
module ram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t     state;
    logic       sel;      // latched winner: 0 = m0, 1 = m1
    logic       sel_we;
    logic [2:0] lat_cnt;
    logic       any_req;
    logic       win;

`ifndef ARB_FIXED_PRIO_EN
    logic rr_last;
`endif

    // Handshake: a requester holds req and payload stable until its one-cycle
    // gnt; read data returns later as a one-cycle rvalid with rdata held after.
    always_comb begin
        any_req = m0_req | m1_req;
`ifdef ARB_FIXED_PRIO_EN
        win = ~m0_req;
`else
        if (m0_req && m1_req) win = ~rr_last;
        else                  win = ~m0_req;
`endif
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state     <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
            rr_last   <= 1'b1;
`endif
            sel       <= 1'b0;
            sel_we    <= 1'b0;
            lat_cnt   <= 3'd0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel      <= win;
                        sel_we   <= win ? m1_we : m0_we;
                        ram_addr <= win ? m1_addr : m0_addr;
                        ram_we   <= win ? m1_we : m0_we;
                        if (win ? m1_we : m0_we)
                            ram_din <= win ? m1_wdata : m0_wdata;
                        m0_gnt   <= ~win;
                        m1_gnt   <= win;
`ifndef ARB_FIXED_PRIO_EN
                        rr_last  <= win;
`endif
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (sel_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // ACCESS counts as latency cycle 0
                        lat_cnt <= 3'd1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT) begin
                        if (sel) begin
                            m1_rdata  <= ram_dout;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= ram_dout;
                            m0_rvalid <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
